// File: rtl/fpga_trace_pkg.sv
// Shared types, constants and entry-layout helpers for the trace capture block.
package fpga_trace_pkg;

  // Width of the channel field in every buffer entry.
  localparam int CHW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Entry layout, LSB first: payload, timestamp, channel, is_ctrl, trig.
  function automatic int pl_width(int aw, int dw);
    return aw + dw;
  endfunction

  function automatic int entry_width(int aw, int dw, int tsw);
    return 2 + CHW + tsw + aw + dw;
  endfunction

  function automatic int ts_lsb(int aw, int dw);
    return aw + dw;
  endfunction

  function automatic int chan_lsb(int aw, int dw, int tsw);
    return aw + dw + tsw;
  endfunction

  function automatic int ctrl_bit(int aw, int dw, int tsw);
    return aw + dw + tsw + CHW;
  endfunction

  function automatic int trig_bit(int aw, int dw, int tsw);
    return aw + dw + tsw + CHW + 1;
  endfunction

  // Adds a small increment to a 16-bit counter, sticking at all-ones.
  function automatic logic [15:0] sat_add16(logic [15:0] a, logic [3:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/fpga_trace_arb.sv
// Fixed-priority selector: request 0 wins, then 1, and so on. Also reports
// how many active requests lost this cycle.
module fpga_trace_arb #(
  parameter int N  = 3,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [IW-1:0] drop_inc
);

  logic [IW-1:0] active;

  // Pick the lowest-numbered request and count the losers.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    active    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      active = active + IW'(req[i]);
    end
    drop_inc = gnt_valid ? active - IW'(1) : '0;
  end

endmodule

// File: rtl/fpga_trace_capture.sv
// On-chip trace recorder: timestamps channel samples and control writes into
// a circular buffer around a trigger, then drains it oldest-first.
module fpga_trace_capture
  import fpga_trace_pkg::*;
#(
  parameter int SW  = 16,
  parameter int AW  = 16,
  parameter int DW  = 32,
  parameter int NCH = 2,
  parameter int DAW = 8,
  parameter int TSW = 16,
  localparam int EW = entry_width(AW, DW, TSW)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               trig_ext,
  input  logic               trig_en_ctrl,
  input  logic [AW-1:0]      trig_addr,
  input  logic [DAW-1:0]     post_count,
  input  logic [NCH*SW-1:0]  ch_sample,
  input  logic [NCH-1:0]     ch_sready,
  input  logic               dut_cready,
  input  logic               dut_cwait,
  input  logic [AW-1:0]      dut_addr,
  input  logic [DW-1:0]      dut_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [EW-1:0]      rd_data,
  output logic               rd_last,
  output logic               busy,
  output logic               done,
  output logic [15:0]        drop_count
);

  localparam int DEPTH    = 1 << DAW;
  localparam int PLW      = pl_width(AW, DW);
  localparam int TS_LSB   = ts_lsb(AW, DW);
  localparam int CHAN_LSB = chan_lsb(AW, DW, TSW);
  localparam int CTRL_BIT = ctrl_bit(AW, DW, TSW);
  localparam int TRIG_BIT = trig_bit(AW, DW, TSW);
  localparam int IW       = CHW + 1;
  localparam int NREQ     = NCH + 1;

  state_t         state, state_nxt;
  logic [DAW-1:0] wr_ptr, rd_ptr, post_rem;
  logic [DAW:0]   fill, rd_cnt;
  logic [TSW-1:0] ts;
  logic           wrapped;
  logic [EW-1:0]  mem [DEPTH];

  logic           ctrl_ev, trig_hit, capturing, wr_en, xfer;
  logic [NREQ-1:0] req;
  logic           gnt_valid;
  logic [IW-1:0]  gnt_idx, drop_inc;
  logic [EW-1:0]  wr_entry;
  logic [DAW-1:0] post_clamped, wr_ptr_nxt;
  logic [DAW:0]   fill_nxt;
  logic           wrapped_nxt;
  int             sel;

  // Control event occupies request slot 0 so it outranks every channel.
  assign ctrl_ev = dut_cready & ~dut_cwait;
  assign req     = {ch_sready, ctrl_ev};

  fpga_trace_arb #(.N(NREQ), .IW(IW)) u_arb (
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .drop_inc  (drop_inc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (arm) state_nxt = ST_ARMED;
        ST_ARMED: if (trig_hit) state_nxt = (post_clamped == '0) ? ST_DONE : ST_TRIG;
        ST_TRIG:  if (wr_en && post_rem == DAW'(1)) state_nxt = ST_DONE;
        ST_DONE:  if (xfer && rd_cnt == (DAW+1)'(1)) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs and the zero-latency readout port.
  always_comb begin
    busy      = (state != ST_IDLE);
    capturing = (state == ST_ARMED || state == ST_TRIG) && !abort;
    rd_valid  = (state == ST_DONE) && (rd_cnt != '0);
    rd_last   = rd_valid && (rd_cnt == (DAW+1)'(1));
    rd_data   = rd_valid ? mem[rd_ptr] : '0;
  end

  // Trigger detection, entry assembly and post-write pointer values.
  always_comb begin
    // A DAW-bit post_count can never exceed DEPTH-1, so the clamp is a pass-through.
    post_clamped = post_count;
    trig_hit     = capturing && (state == ST_ARMED) &&
                   (trig_ext || (trig_en_ctrl && ctrl_ev && dut_addr == trig_addr));
    wr_en        = capturing && (gnt_valid || trig_hit);
    xfer         = rd_valid && rd_ready && !abort;

    sel      = 0;
    wr_entry = '0;
    wr_entry[TRIG_BIT] = trig_hit;
    wr_entry[TS_LSB +: TSW] = ts;
    if (gnt_valid) begin
      if (gnt_idx == '0) begin
        wr_entry[CTRL_BIT] = 1'b1;
        wr_entry[PLW-1:0]  = {dut_addr, dut_data};
      end else begin
        sel = int'(gnt_idx) - 1;
        wr_entry[CHAN_LSB +: CHW] = CHW'(gnt_idx - IW'(1));
        wr_entry[SW-1:0]          = ch_sample[sel*SW +: SW];
      end
    end

    wr_ptr_nxt  = wr_ptr + DAW'(wr_en);
    fill_nxt    = (wr_en && fill != (DAW+1)'(DEPTH)) ? fill + (DAW+1)'(1) : fill;
    wrapped_nxt = wrapped || (wr_en && wr_ptr == DAW'(DEPTH - 1));
  end

  // Buffer write port.
  // NOTE: the entry array is deliberately left out of reset; readout only ever
  // touches slots written during the current capture.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // Pointers, timestamp, post-trigger countdown, drop counter and done pulse.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignment so every update sees
    // the pre-edge values of its neighbours.
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      rd_cnt     <= '0;
      ts         <= '0;
      post_rem   <= '0;
      wrapped    <= 1'b0;
      drop_count <= '0;
      done       <= 1'b0;
    end else begin
      done <= xfer && (rd_cnt == (DAW+1)'(1));

      if (state == ST_IDLE && arm && !abort) begin
        wr_ptr     <= '0;
        fill       <= '0;
        ts         <= '0;
        drop_count <= '0;
        wrapped    <= 1'b0;
      end

      if (capturing) begin
        ts         <= ts + TSW'(1);
        drop_count <= sat_add16(drop_count, drop_inc);
        wr_ptr     <= wr_ptr_nxt;
        fill       <= fill_nxt;
        wrapped    <= wrapped_nxt;
        if (trig_hit)                      post_rem <= post_clamped;
        else if (state == ST_TRIG && wr_en) post_rem <= post_rem - DAW'(1);
      end

      // Entering DONE: oldest entry sits at wr_ptr once the buffer has wrapped.
      if (state != ST_DONE && state_nxt == ST_DONE) begin
        rd_ptr <= wrapped_nxt ? wr_ptr_nxt : '0;
        rd_cnt <= fill_nxt;
      end else if (xfer) begin
        rd_ptr <= rd_ptr + DAW'(1);
        rd_cnt <= rd_cnt - (DAW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_fpga_trace_capture.sv
// Randomised bench for fpga_trace_capture with a transaction-level model:
// the model keeps a log of written entries and expects the newest DEPTH of
// them back, oldest first.
module tb_fpga_trace_capture;

  localparam int SW = 16, AW = 16, DW = 32, NCH = 2, DAW = 3, TSW = 16;
  localparam int EW    = 2 + 3 + TSW + AW + DW;
  localparam int DEPTH = 1 << DAW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              arm = 1'b0, abort = 1'b0, trig_ext = 1'b0, trig_en_ctrl = 1'b0;
  logic [AW-1:0]     trig_addr = '0;
  logic [DAW-1:0]    post_count = '0;
  logic [NCH*SW-1:0] ch_sample = '0;
  logic [NCH-1:0]    ch_sready = '0;
  logic              dut_cready = 1'b0, dut_cwait = 1'b0;
  logic [AW-1:0]     dut_addr = '0;
  logic [DW-1:0]     dut_data = '0;
  logic              rd_valid, rd_ready = 1'b0, rd_last, busy, done;
  logic [EW-1:0]     rd_data;
  logic [15:0]       drop_count;

  always #5 clk = ~clk;

  fpga_trace_capture #(
    .SW(SW), .AW(AW), .DW(DW), .NCH(NCH), .DAW(DAW), .TSW(TSW)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .trig_ext(trig_ext), .trig_en_ctrl(trig_en_ctrl), .trig_addr(trig_addr),
    .post_count(post_count), .ch_sample(ch_sample), .ch_sready(ch_sready),
    .dut_cready(dut_cready), .dut_cwait(dut_cwait), .dut_addr(dut_addr),
    .dut_data(dut_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .busy(busy), .done(done),
    .drop_count(drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] m_log[$];
  logic [EW-1:0] m_rdq[$];
  bit            m_busy, m_cap, m_trig, m_reading, m_done;
  int            m_post, m_ri, m_drop;
  logic [15:0]   m_ts;

  function automatic logic [EW-1:0] mk(input logic t, input logic c, input logic [2:0] ch,
                                       input logic [15:0] ts, input logic [47:0] pl);
    return {t, c, ch, ts, pl};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cap = 0; m_trig = 0; m_reading = 0; m_done = 0;
    m_post = 0; m_ri = 0; m_drop = 0; m_ts = '0;
    m_log.delete(); m_rdq.delete();
  endtask

  // Apply one clock cycle of the current inputs to the model.
  task automatic model_cycle();
    logic ce, hit, wrote;
    logic [EW-1:0] e;
    int nact;
    m_done = 0;
    if (abort) begin
      m_busy = 0; m_cap = 0; m_reading = 0;
    end else if (!m_busy) begin
      if (arm) begin
        m_busy = 1; m_cap = 1; m_trig = 0; m_ts = '0; m_drop = 0;
        m_log.delete();
      end
    end else if (m_cap) begin
      ce    = dut_cready && !dut_cwait;
      hit   = !m_trig && (trig_ext || (trig_en_ctrl && ce && dut_addr == trig_addr));
      nact  = int'(ce) + int'(ch_sready[0]) + int'(ch_sready[1]);
      wrote = 1'b1;
      e     = '0;
      if (ce)                e = mk(hit, 1'b1, 3'd0, m_ts, {dut_addr, dut_data});
      else if (ch_sready[0]) e = mk(hit, 1'b0, 3'd0, m_ts, {32'b0, ch_sample[15:0]});
      else if (ch_sready[1]) e = mk(hit, 1'b0, 3'd1, m_ts, {32'b0, ch_sample[31:16]});
      else if (hit)          e = mk(1'b1, 1'b0, 3'd0, m_ts, 48'b0);
      else                   wrote = 1'b0;
      if (nact > 1) begin
        m_drop = m_drop + nact - 1;
        if (m_drop > 65535) m_drop = 65535;
      end
      if (wrote) begin
        m_log.push_back(e);
        if (m_log.size() > DEPTH) void'(m_log.pop_front());
      end
      m_ts = m_ts + 16'd1;
      if (hit) begin
        m_trig = 1;
        m_post = int'(post_count);
      end else if (m_trig && wrote) begin
        m_post--;
      end
      if (m_trig && m_post == 0) begin
        m_cap = 0; m_reading = 1; m_rdq = m_log; m_ri = 0;
      end
    end else if (m_reading) begin
      if (rd_ready) begin
        m_ri++;
        if (m_ri == m_rdq.size()) begin
          m_reading = 0; m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  // One clock: update the model, advance the DUT, compare just after the edge.
  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("drop_count", drop_count, m_drop);
    check("rd_valid", rd_valid, m_reading);
    if (m_reading) begin
      check("rd_data", rd_data, m_rdq[m_ri]);
      check("rd_last", rd_last, m_ri == m_rdq.size() - 1);
    end
  endtask

  task automatic idle_inputs();
    arm = 0; abort = 0; trig_ext = 0;
    ch_sready = '0; ch_sample = '0;
    dut_cready = 0; dut_cwait = 0; dut_addr = '0; dut_data = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_done", done, 0);
    check("rst_drop", drop_count, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 0;
    model_reset();
  endtask

  task automatic arm_capture();
    arm = 1;
    tick();
    arm = 0;
  endtask

  // mode 0: always ready, 1: 1010 toggle, 2: random
  task automatic readout(input int mode);
    int c;
    c = 0;
    while (m_reading && c < 200) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (c % 2 == 0);
        default: rd_ready = 1'($urandom);
      endcase
      tick();
      c++;
    end
    rd_ready = 0;
    check("readout_timeout", m_reading, 0);
    if (m_reading) begin
      abort = 1; tick(); abort = 0;
    end
    tick();
  endtask

  task automatic run_basic();
    post_count = 3'd2;
    arm_capture();
    for (int i = 0; i < 5; i++) begin
      ch_sready = 2'b01;
      ch_sample = {16'h0, 16'(16'hA0 + i)};
      trig_ext  = (i == 2);
      tick();
    end
    idle_inputs();
  endtask

  task automatic rand_session(input int mode);
    int trig_at;
    post_count   = 3'($urandom_range(0, 7));
    trig_en_ctrl = 1'($urandom);
    trig_addr    = 16'h0040;
    arm_capture();
    trig_at = $urandom_range(0, 25);
    for (int c = 0; c < 400 && m_cap; c++) begin
      ch_sready  = 2'($urandom);
      ch_sample  = $urandom;
      dut_cready = ($urandom_range(0, 3) == 0);
      dut_cwait  = ($urandom_range(0, 3) == 0);
      dut_addr   = ($urandom_range(0, 1) == 1) ? 16'h0040 : 16'($urandom);
      dut_data   = $urandom;
      trig_ext   = (c == trig_at) || (c > trig_at && $urandom_range(0, 3) == 0);
      arm        = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle_inputs();
    if (m_cap) begin
      abort = 1; tick(); abort = 0;
    end
    readout(mode);
  endtask

  initial begin
    model_reset();
    do_reset();
    tick();

    // Basic capture: trigger on the third of five samples, two after.
    run_basic();
    readout(0);

    // Wrap: 20 ch1 samples, then a marker trigger with no window.
    post_count = 3'd0;
    arm_capture();
    for (int i = 0; i < 20; i++) begin
      ch_sready = 2'b10;
      ch_sample = {16'(i), 16'hFFFF};
      tick();
    end
    ch_sready = '0;
    trig_ext  = 1;
    tick();
    idle_inputs();
    readout(1);

    // Three simultaneous events until the drop counter saturates, then abort.
    post_count = 3'd7;
    trig_en_ctrl = 0;
    arm_capture();
    for (int i = 0; i < 'h10000; i++) begin
      dut_cready = 1; dut_cwait = 0;
      dut_addr = 16'($urandom); dut_data = $urandom;
      ch_sready = 2'b11; ch_sample = $urandom;
      tick();
    end
    check("drop_saturated", drop_count, 16'hFFFF);
    idle_inputs();
    abort = 1; tick(); abort = 0;
    tick();

    // Address-match trigger must wait for the un-stalled cycle.
    trig_en_ctrl = 1; trig_addr = 16'h0040; post_count = 3'd1;
    arm_capture();
    dut_cready = 1; dut_cwait = 0; dut_addr = 16'h0041; dut_data = 32'h1111_2222; tick();
    dut_cwait = 1; dut_addr = 16'h0040; dut_data = 32'hDEAD_BEEF; tick();
    dut_cwait = 0; tick();
    idle_inputs();
    ch_sready = 2'b01; ch_sample = 32'h0000_5A5A; tick();
    idle_inputs();
    readout(2);
    trig_en_ctrl = 0;

    // Randomised sessions with assorted readout back-pressure.
    for (int s = 0; s < 8; s++) rand_session(s % 3);

    // Abort while in the post-trigger window.
    post_count = 3'd5;
    arm_capture();
    dut_cready = 1; ch_sready = 2'b01; ch_sample = 32'h7; tick();
    idle_inputs();
    trig_ext = 1; tick();
    idle_inputs();
    ch_sready = 2'b10; ch_sample = 32'h0009_0000; tick();
    idle_inputs();
    abort = 1; tick(); abort = 0;
    tick();

    // arm together with abort in IDLE stays idle.
    arm = 1; abort = 1; tick();
    idle_inputs();
    tick();

    // Abort during readout.
    run_basic();
    tick();
    abort = 1; tick(); abort = 0;
    tick();

    // Reset during readout with rd_valid high, then a clean capture.
    run_basic();
    rd_ready = 1; tick(); rd_ready = 0;
    tick();
    do_reset();
    tick();
    run_basic();
    readout(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
